// File: rtl/i2c_slave_axis.sv
// i2c_slave_axis: I2C target that streams written bytes out on AXIS and returns AXIS bytes on reads
module i2c_slave_axis #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
  state_t                state_q, state_d;
  logic [2:0]            scl_sync_q, sda_sync_q;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, mdata_q, mdata_d, byte_in;
  logic                  rw_q, rw_d, ack_q, ack_d, sda_q, sda_d, mvalid_q, mvalid_d;
  logic                  scl, sda, rise, fall, start, stop, ld;
  assign scl     = scl_sync_q[1];
  assign sda     = sda_sync_q[1];
  assign rise    = scl & ~scl_sync_q[2];
  assign fall    = ~scl & scl_sync_q[2];
  assign start   = scl & sda_sync_q[2] & ~sda;
  assign stop    = scl & ~sda_sync_q[2] & sda;
  assign byte_in = {sr_q[DATA_WIDTH-2:0], sda};
  assign sda_o         = sda_q;
  assign m_axis_tdata  = mdata_q;
  assign m_axis_tvalid = mvalid_q;
  // Bus framing, byte shifting, ACK phases and AXIS handshakes
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sr_d          = sr_q;
    rw_d          = rw_q;
    ack_d         = ack_q;
    sda_d         = sda_q;
    mdata_d       = mdata_q;
    mvalid_d      = mvalid_q & ~m_axis_tready;
    s_axis_tready = 1'b0;
    ld            = 1'b0;
    if (start) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      sda_d   = 1'b1;
      ack_d   = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (rise) begin
          sr_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rw_d    = sda;
            state_d = (sr_q[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
          end
        end
        ADDR_ACK, WR_ACK: if (fall) begin
          ack_d = ~ack_q;
          sda_d = ack_q;
          if (ack_q) begin
            if (state_q == WR_ACK || !rw_q) state_d = WR_DATA;
            else ld = 1'b1;
          end
        end
        WR_DATA: if (rise) begin
          sr_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = mvalid_q ? WAIT_STOP : WR_ACK;
            if (!mvalid_q) begin
              mdata_d  = byte_in;
              mvalid_d = 1'b1;
            end
          end
        end
        RD_DATA: if (rise) begin
          cnt_d = cnt_q + 3'd1;
          sr_d  = {sr_q[DATA_WIDTH-2:0], 1'b0};
        end else if (fall) begin
          sda_d   = (cnt_q == 3'd0) ? 1'b1 : sr_q[DATA_WIDTH-1];
          state_d = (cnt_q == 3'd0) ? RD_ACK : RD_DATA;
        end
        RD_ACK: if (rise) begin
          state_d = sda ? WAIT_STOP : RD_ACK;
          ack_d   = ~sda;
        end else if (fall && ack_q) begin
          ack_d = 1'b0;
          ld    = 1'b1;
        end
        default: ;
      endcase
    end
    if (ld) begin
      s_axis_tready = s_axis_tvalid;
      sr_d          = s_axis_tvalid ? s_axis_tdata : '1;
      sda_d         = s_axis_tvalid ? s_axis_tdata[DATA_WIDTH-1] : 1'b1;
      state_d       = RD_DATA;
    end
  end
  // Input synchronizers with history flop for edge detection
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_i};
      sda_sync_q <= {sda_sync_q[1:0], sda_i};
    end
  end
  // State and datapath registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      sr_q     <= '0;
      rw_q     <= 1'b0;
      ack_q    <= 1'b0;
      sda_q    <= 1'b1;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      rw_q     <= rw_d;
      ack_q    <= ack_d;
      sda_q    <= sda_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
    end
  end
endmodule

// File: tb/tb_i2c_slave_axis.sv
// tb_i2c_slave_axis: directed bus-master stimulus with table-driven write vectors and read/corner sequences
module tb_i2c_slave_axis;
  localparam int H = 16;
  localparam int Q = 4;
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       a_ack;
    logic       d_ack;
  } vec_t;
  logic       clk = 1'b0, arstn = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic       sda_o, sda_line;
  logic [7:0] m_tdata, s_tdata;
  logic       m_tvalid, s_tvalid, s_tready;
  logic       m_tready = 1'b1;
  logic [7:0] tx_mem [8];
  int         tx_cnt = 0, tx_ptr = 0;
  int         beats = 0, tready_cyc = 0, low_cyc = 0;
  logic [7:0] last_beat = 8'h00;
  int         n_tests = 0, n_fail = 0;
  vec_t       vecs [5];
  assign sda_line = sda_m & sda_o;
  assign s_tvalid = tx_ptr < tx_cnt;
  assign s_tdata  = s_tvalid ? tx_mem[tx_ptr[2:0]] : 8'h00;
  always #5 clk = ~clk;
  i2c_slave_axis dut (
    .clk_i(clk), .arstn_i(arstn), .scl_i(scl), .sda_i(sda_line), .sda_o(sda_o),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready)
  );
  // Observe AXIS handshakes, tready activity and SDA pull-down cycles
  always @(posedge clk) begin
    if (m_tvalid && m_tready) begin
      beats     <= beats + 1;
      last_beat <= m_tdata;
    end
    if (s_tready) tready_cyc <= tready_cyc + 1;
    if (s_tready && s_tvalid) tx_ptr <= tx_ptr + 1;
    if (!sda_o) low_cyc <= low_cyc + 1;
  end
  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic bus_start();
    sda_m = 1'b1; w(H); scl = 1'b1; w(H); sda_m = 1'b0; w(H); scl = 1'b0; w(Q);
  endtask
  task automatic bus_stop();
    sda_m = 1'b0; w(H); scl = 1'b1; w(H); sda_m = 1'b1; w(H);
  endtask
  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; w(H); scl = 1'b1; w(H); scl = 1'b0; w(Q);
    end
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    sda_m = 1'b1; w(H); scl = 1'b1; w(H/2); ack = ~sda_line; w(H/2); scl = 1'b0; w(Q);
  endtask
  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; w(H); scl = 1'b1; w(H/2); b[i] = sda_line; w(H/2); scl = 1'b0; w(Q);
    end
    sda_m = ~mack; w(H); scl = 1'b1; w(H); scl = 1'b0; w(Q);
  endtask
  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_cnt[2:0]] = b;
    tx_cnt++;
  endtask
  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic       a, d;
    logic [7:0] b0, b1;
    int         bb, lc, p0, r0;
    vecs[0] = '{8'hA0, 8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'hA2, 8'h12, 1'b0, 1'b0};
    vecs[2] = '{8'hA0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'hA0, 8'hFF, 1'b1, 1'b1};
    vecs[4] = '{8'h20, 8'h5A, 1'b0, 1'b0};
    w(4);
    check("rst_sda_o", sda_o, 1);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s_tready", s_tready, 0);
    arstn = 1'b1;
    w(4);
    for (int v = 0; v < 5; v++) begin
      bb = beats; lc = low_cyc;
      bus_start();
      write_byte(vecs[v].addr, a);
      write_byte(vecs[v].data, d);
      bus_stop();
      w(4);
      check($sformatf("v%0d_addr_ack", v), a, vecs[v].a_ack);
      check($sformatf("v%0d_data_ack", v), d, vecs[v].d_ack);
      check($sformatf("v%0d_beats", v), beats - bb, vecs[v].d_ack ? 1 : 0);
      if (vecs[v].d_ack) check($sformatf("v%0d_beat_data", v), last_beat, vecs[v].data);
      check($sformatf("v%0d_sda_pulled", v), low_cyc != lc, vecs[v].a_ack);
      check($sformatf("v%0d_idle_sda", v), sda_o, 1);
      check($sformatf("v%0d_idle_tvalid", v), m_tvalid, 0);
    end
    push_tx(8'h3C); push_tx(8'hC3);
    p0 = tx_ptr; r0 = tready_cyc;
    bus_start();
    write_byte(8'hA1, a);
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    bus_stop();
    w(4);
    check("rd_addr_ack", a, 1);
    check("rd_byte0", b0, 8'h3C);
    check("rd_byte1", b1, 8'hC3);
    check("rd_pops", tx_ptr - p0, 2);
    check("rd_tready_cycles", tready_cyc - r0, 2);
    r0 = tready_cyc;
    bus_start();
    write_byte(8'hA1, a);
    read_byte(1'b0, b0);
    bus_stop();
    w(4);
    check("ur_addr_ack", a, 1);
    check("ur_byte", b0, 8'hFF);
    check("ur_tready_cycles", tready_cyc - r0, 0);
    push_tx(8'h77);
    p0 = tx_ptr;
    bus_start();
    write_byte(8'hA0, a);
    bus_start();
    write_byte(8'hA1, d);
    read_byte(1'b0, b0);
    bus_stop();
    w(4);
    check("sr_first_ack", a, 1);
    check("sr_second_ack", d, 1);
    check("sr_byte", b0, 8'h77);
    check("sr_pops", tx_ptr - p0, 1);
    bus_start();
    send_bits(8'hA0);
    check("mid_ack_drive", sda_o, 0);
    arstn = 1'b0;
    #1;
    check("mid_rst_release", sda_o, 1);
    bus_stop();
    w(2);
    arstn = 1'b1;
    w(4);
    bb = beats;
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h42, d);
    bus_stop();
    w(4);
    check("post_rst_acks", {a, d}, 2'b11);
    check("post_rst_beats", beats - bb, 1);
    check("post_rst_data", last_beat, 8'h42);
    m_tready = 1'b0;
    bb = beats;
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h11, d);
    write_byte(8'h22, b0[0]);
    bus_stop();
    w(4);
    check("bp_acks", {a, d}, 2'b11);
    check("bp_nack", b0[0], 0);
    check("bp_held_valid", m_tvalid, 1);
    check("bp_held_data", m_tdata, 8'h11);
    check("bp_no_beat", beats - bb, 0);
    m_tready = 1'b1;
    w(3);
    check("bp_one_beat", beats - bb, 1);
    check("bp_beat_data", last_beat, 8'h11);
    check("bp_valid_cleared", m_tvalid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_axis.md
I2C_SLAVE_AXIS -- requirements
Module: i2c_slave_axis

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, 7-bit device address this responder answers to.
REQ-002 Parameter DATA_WIDTH, default 8, AXIS tdata width; fixed to 8 in this revision.
REQ-003 clk_i  input  1  system clock, all logic on rising edge.
REQ-004 arstn_i  input  1  reset, asynchronous, active-low.
REQ-005 scl_i  input  1  I2C clock from bus, asynchronous to clk_i.
REQ-006 sda_i  input  1  I2C data from bus, asynchronous to clk_i.
REQ-007 sda_o  output  1  open-drain data drive; 0 = pull low, 1 = release.
REQ-008 m_axis  axis_if.master  8  bytes written by the bus master (tdata, tvalid, tready).
REQ-009 s_axis  axis_if.slave  8  bytes to return on bus read transfers (tdata, tvalid, tready).

Function
REQ-010 scl_i and sda_i SHALL each pass a 2-flop synchronizer plus one history flop; edges are detected on the synchronized values.
REQ-011 START SHALL be detected when SDA falls while SCL is high; STOP SHALL be detected when SDA rises while SCL is high.
REQ-012 FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-013 START or repeated START in any state SHALL go to ADDR, clear the bit counter, and release sda_o.
REQ-014 STOP in any state SHALL go to IDLE and release sda_o.
REQ-015 Data bits SHALL be sampled on SCL rising edges, MSB first; the 3-bit bit counter wraps 7 to 0 after each byte.
REQ-016 ADDR: after 8 bits, if the upper 7 bits equal SLAVE_ADDR, go to ADDR_ACK and latch the R/W bit; otherwise go to WAIT_STOP without driving SDA.
REQ-017 An ACK SHALL drive sda_o=0 from the SCL falling edge after bit 8 to the SCL falling edge after the 9th clock.
REQ-018 ADDR_ACK with R/W=0 SHALL go to WR_DATA; with R/W=1 it SHALL load the transmit byte (REQ-022) and go to RD_DATA.
REQ-019 WR_DATA: after 8 bits, if the output holding register is empty, store the byte, set m_axis.tvalid, and ACK; otherwise NACK, drop the byte, and go to WAIT_STOP.
REQ-020 m_axis.tvalid SHALL stay high with tdata stable until tready; it clears on the cycle after the handshake.
REQ-021 WR_ACK SHALL return to WR_DATA after the 9th SCL falling edge.
REQ-022 Transmit load: if s_axis.tvalid, capture tdata and pulse s_axis.tready for exactly one cycle; else load 8'hFF with tready held low (underrun).
REQ-023 RD_DATA: sda_o SHALL present the shift-register MSB after each SCL falling edge, with sda_o=1 where the bit is 1.
REQ-024 RD_DATA: after 8 bits, release SDA and go to RD_ACK; the master's ACK bit is sampled on the SCL rising edge.
REQ-025 RD_ACK with master ACK (SDA=0) SHALL perform the transmit load and return to RD_DATA.
REQ-026 RD_ACK with master NACK SHALL go to WAIT_STOP with no further s_axis pop.
REQ-027 WAIT_STOP SHALL keep sda_o released and ignore SCL edges until START or STOP.
REQ-028 s_axis.tready SHALL never be high outside a transmit-load cycle.
REQ-029 START detected on the same cycle as an SCL edge SHALL take priority; that SCL edge is ignored.

Reset
REQ-030 While arstn_i is low: state IDLE, sda_o=1, m_axis.tvalid=0, m_axis.tdata=0, s_axis.tready=0, counters and shift registers 0.
REQ-031 Reset asserted mid-transfer SHALL release SDA immediately; after release, the block waits in IDLE for a fresh START.

Verification
REQ-032 Write: START, addr 0x50+W, data 0xA5, STOP, m_axis.tready=1 -> ACK on both bytes, one m_axis beat of 0xA5, idle afterwards.
REQ-033 Address mismatch: START, 0x51+W, 0x12, STOP -> sda_o stays 1 throughout, no m_axis beat.
REQ-034 Write backpressure: m_axis.tready=0, write 0x11 then 0x22 -> 0x11 ACKed and held valid, 0x22 NACKed; release tready -> exactly one beat of 0x11.
REQ-035 Read: s_axis offers 0x3C, 0xC3; master reads with ACK then NACK, then STOP -> bus sees 0x3C, 0xC3; exactly two s_axis pops.
REQ-036 Read underrun: s_axis.tvalid=0, read one byte -> bus sees 0xFF, s_axis.tready never asserted.
REQ-037 Repeated START: write 0x50+W, then Sr, then 0x50+R, read one byte -> ADDR re-entered, second address ACKed, read data correct.
